// File: rtl/split_drv_pkg.sv
// rtl/split_drv_pkg.sv - shared states, LFSR polynomial and per-variable width table for split_assign_driver
package split_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PRESENT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Width table of the split_18 checker input set
  localparam int VAR_CNT = 50;
  localparam int VAR_W [VAR_CNT] = '{
    11, 4, 11, 6, 12, 12, 5, 15, 13, 8,
    4, 6, 5, 15, 16, 5, 12, 15, 9, 10,
    8, 16, 7, 12, 9, 10, 15, 13, 11, 4,
    10, 15, 10, 15, 4, 14, 6, 13, 9, 6,
    14, 9, 16, 14, 15, 16, 4, 6, 5, 16
  };

  // Low-order ones mask for variable k; variables past the table get no bits
  function automatic logic [31:0] var_mask(int k);
    if (k < 0 || k >= VAR_CNT) return '0;
    return (32'h1 << VAR_W[k]) - 32'h1;
  endfunction

endpackage

// File: rtl/split_assign_driver_if.sv
// rtl/split_assign_driver_if.sv - control, assignment and result bundle between driver and its host
interface split_drv_if #(
  parameter int NUM_VARS = 50,
  parameter int MAX_W    = 16,
  parameter int CNT_W    = 16
);
  logic                      start;
  logic [CNT_W-1:0]          num_samples;
  logic [31:0]               seed;
  logic [NUM_VARS*MAX_W-1:0] assignment;
  logic                      assign_valid;
  logic                      chk_x;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          pass_cnt;
  logic [CNT_W-1:0]          fail_cnt;
  logic [CNT_W-1:0]          fail_idx;

  modport master (
    input  start, num_samples, seed, chk_x,
    output assignment, assign_valid, busy, done, pass_cnt, fail_cnt, fail_idx
  );

  modport slave (
    output start, num_samples, seed, chk_x,
    input  assignment, assign_valid, busy, done, pass_cnt, fail_cnt, fail_idx
  );
endinterface

// File: rtl/split_drv_lfsr.sv
// rtl/split_drv_lfsr.sv - 32-bit right-shifting Galois LFSR with seed load and advance enable
module split_drv_lfsr
  import split_drv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  // Load has priority; a zero seed would lock the LFSR so it is replaced by 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 32'h1;
    end else if (load) begin
      value <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/split_assign_driver.sv
// rtl/split_assign_driver.sv - pseudo-random assignment driver and pass/fail tally for split_N checkers (option: SPLIT_DRV_FAIL_CAPTURE_EN)
module split_assign_driver
  import split_drv_pkg::*;
#(
  parameter int NUM_VARS = 50,
  parameter int MAX_W    = 16,
  parameter int CHK_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input logic        clk,
  input logic        rst,
  split_drv_if.master bus
);

  localparam int VI_W  = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam int LAT_W = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

  state_t                    state;
  state_t                    state_nxt;
  logic [VI_W-1:0]           var_idx;
  logic [LAT_W-1:0]          lat_cnt;
  logic [CNT_W-1:0]          sample_idx;
  logic [CNT_W-1:0]          num_samples;
  logic [CNT_W-1:0]          pass_cnt;
  logic [CNT_W-1:0]          fail_cnt;
  logic [NUM_VARS*MAX_W-1:0] assignment;
  logic [31:0]               lfsr_q;
  logic [MAX_W-1:0]          slot;
  logic                      start_acc;
  logic                      fill_last;
  logic                      lat_done;
  logic                      last_sample;

  assign start_acc   = bus.start && (state == IDLE || state == DONE);
  assign fill_last   = (var_idx == VI_W'(NUM_VARS - 1));
  assign lat_done    = (lat_cnt == LAT_W'(CHK_LAT - 1));
  assign last_sample = (CNT_W'(sample_idx + 1) == num_samples);
  assign slot        = MAX_W'(lfsr_q & var_mask(int'(var_idx)));

  split_drv_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_acc),
    .advance (state == FILL),
    .seed    (bus.seed),
    .value   (lfsr_q)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: fill all slots, hold for checker latency, sample once
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = (bus.num_samples == '0) ? DONE : FILL;
      FILL:       if (fill_last) state_nxt = PRESENT;
      PRESENT:    if (lat_done) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last_sample ? DONE : FILL;
      default:    state_nxt = IDLE;
    endcase
  end

  // Assignment build, latency count and saturating result tallies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      var_idx     <= '0;
      lat_cnt     <= '0;
      sample_idx  <= '0;
      num_samples <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      assignment  <= '0;
    end else if (start_acc) begin
      var_idx     <= '0;
      lat_cnt     <= '0;
      sample_idx  <= '0;
      num_samples <= bus.num_samples;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      assignment  <= '0;
    end else begin
      if (state == FILL) begin
        assignment[var_idx*MAX_W +: MAX_W] <= slot;
        var_idx <= fill_last ? '0 : VI_W'(var_idx + 1);
      end
      if (state == PRESENT) begin
        lat_cnt <= lat_done ? '0 : LAT_W'(lat_cnt + 1);
      end
      if (state == SAMPLE) begin
        if (bus.chk_x) begin
          if (pass_cnt != '1) pass_cnt <= CNT_W'(pass_cnt + 1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= CNT_W'(fail_cnt + 1);
        end
        sample_idx <= CNT_W'(sample_idx + 1);
      end
    end
  end

`ifdef SPLIT_DRV_FAIL_CAPTURE_EN
  logic [CNT_W-1:0] fail_idx_q;

  // Remember the index of the first failing sample; fail_cnt still zero marks "first"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_idx_q <= '0;
    end else if (start_acc) begin
      fail_idx_q <= '0;
    end else if (state == SAMPLE && !bus.chk_x && fail_cnt == '0) begin
      fail_idx_q <= sample_idx;
    end
  end

  assign bus.fail_idx = fail_idx_q;
`else
  assign bus.fail_idx = '0;
`endif

  assign bus.assignment   = assignment;
  assign bus.assign_valid = (state == PRESENT) || (state == SAMPLE);
  assign bus.busy         = (state == FILL) || (state == PRESENT) || (state == SAMPLE);
  assign bus.done         = (state == DONE);
  assign bus.pass_cnt     = pass_cnt;
  assign bus.fail_cnt     = fail_cnt;

endmodule
